// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared PC-select encodings, fetch FSM states and reset PC
package riscv_pkg;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC target mux with misalignment flag
module next_pc_sel
  import riscv_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic [1:0]  PCSrc,
  output logic [31:0] Target,
  output logic        Misaligned
);

  always_comb begin
    Target = PC + 32'd4;
    case (PCSrc)
      PC_IMM:  Target = PC + ImmExt;
      PC_JALR: Target = {ALUResult[31:1], 1'b0};
      default: Target = PC + 32'd4;  // reserved encoding behaves as PC+4
    endcase
  end

  assign Misaligned = |Target[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and req/ack instruction fetcher with bus watchdog
// Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        Commit,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        BusErr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        Trap,
  output logic [31:0] TrapAddr
`endif
);

  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         bus_err_q;
  logic [31:0]  wdog_cnt;
  logic [31:0]  target;
  logic         misaligned;

  next_pc_sel u_next_pc_sel (
    .PC         (pc_q),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .PCSrc      (PCSrc),
    .Target     (target),
    .Misaligned (misaligned)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_addr_q;
  assign Trap     = trap_q;
  assign TrapAddr = trap_addr_q;
`else
  logic [31:0] next_pc;
  // Without trapping, the low two target bits are simply dropped.
  assign next_pc = misaligned ? {target[31:2], 2'b00} : target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      bus_err_q <= 1'b0;
      wdog_cnt  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          wdog_cnt <= '0;
        end
        ST_FETCH: begin
          // Ack is checked first so it wins over a same-cycle watchdog expiry.
          if (IMemAck) begin
            instr_q <= IMemRdata;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end else if (TIMEOUT != 0 && wdog_cnt == WDOG_LAST) begin
            bus_err_q <= 1'b1;
            state     <= ST_ERROR;
          end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
          end
        end
        ST_HOLD: begin
          if (Commit) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              trap_q      <= 1'b1;
              trap_addr_q <= target;
              state       <= ST_ERROR;
            end else begin
              pc_q     <= target;
              wdog_cnt <= '0;
              state    <= ST_FETCH;
            end
`else
            pc_q     <= next_pc;
            wdog_cnt <= '0;
            state    <= ST_FETCH;
`endif
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMemReq    = (state == ST_FETCH);
  assign IMemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign BusErr     = bus_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit (TIMEOUT = 4)
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRdata;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Commit;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        BusErr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        Trap;
  logic [31:0] TrapAddr;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemRdata  (IMemRdata),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .Commit     (Commit),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .BusErr     (BusErr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .Trap       (Trap),
    .TrapAddr   (TrapAddr)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && IMemReq !== 1'b1; i++) @(negedge clk);
    if (IMemReq !== 1'b1) check({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] data, input bit commit_in_fetch);
    exp_t e;
    e = '{addr: exp_pc, instr: data};
    wait_req("fetch");
    check("fetch_addr", IMemAddr, exp_pc);
    sb.push_back(e);
    for (int k = 0; k < delay; k++) begin
      if (commit_in_fetch) Commit = 1'b1;
      @(negedge clk);
      Commit = 1'b0;
      check("addr_stable", IMemAddr, exp_pc);
      check("req_held", {31'd0, IMemReq}, 32'd1);
      check("valid_low_in_fetch", {31'd0, InstrValid}, 32'd0);
    end
    IMemAck   = 1'b1;
    IMemRdata = data;
    @(negedge clk);
    IMemAck   = 1'b0;
    IMemRdata = $urandom;
    check("valid", {31'd0, InstrValid}, 32'd1);
    check("req_drop_in_hold", {31'd0, IMemReq}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("instr", Instr, e.instr);
      check("pc", PC, e.addr);
      check("pc_plus4", PCPlus4, e.addr + 32'd4);
    end
    last_instr = data;
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] t;
    case (src)
      2'd1:    t = exp_pc + imm;
      2'd2:    t = alu & ~32'd1;
      default: t = exp_pc + 32'd4;
    endcase
    PCSrc = src; ImmExt = imm; ALUResult = alu; Commit = 1'b1;
    @(negedge clk);
    Commit = 1'b0; PCSrc = 2'd0; ImmExt = $urandom; ALUResult = $urandom;
    check("commit_valid_drop", {31'd0, InstrValid}, 32'd0);
    check("commit_req_next", {31'd0, IMemReq}, 32'd1);
    exp_pc = {t[31:2], 2'b00};
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; IMemAck = 1'b0; IMemRdata = '0; Commit = 1'b0;
    PCSrc = 2'd0; ImmExt = '0; ALUResult = '0; exp_pc = 32'h0; last_instr = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_buserr", {31'd0, BusErr}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_trap", {31'd0, Trap}, 32'd0);
    check("rst_trapaddr", TrapAddr, 32'd0);
`endif
    rst_n = 1'b1;
    check("idle_req", {31'd0, IMemReq}, 32'd0);

    do_fetch(1, 32'h0000_0013, 1'b0);
    do_commit(2'd0, 32'h0, 32'h0);
    check("seq_addr", IMemAddr, 32'h4);
    do_fetch(0, 32'h0000_0063, 1'b0);
    do_commit(2'd1, 32'h0000_00FC, 32'h0);
    check("branch_fwd_addr", IMemAddr, 32'h100);
    do_fetch(0, 32'h0040_006F, 1'b0);
    do_commit(2'd1, 32'hFFFF_FFF0, 32'h0);
    check("branch_back_addr", IMemAddr, 32'hF0);
    // ack lands on the watchdog's final count while Commit is pulsed in FETCH
    do_fetch(3, 32'h0000_8067, 1'b1);
    check("no_buserr_on_ack", {31'd0, BusErr}, 32'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
    PCSrc = 2'd2; ALUResult = 32'h203; Commit = 1'b1;
    @(negedge clk);
    Commit = 1'b0; PCSrc = 2'd0;
    check("trap", {31'd0, Trap}, 32'd1);
    check("trap_addr", TrapAddr, 32'h202);
    check("trap_req", {31'd0, IMemReq}, 32'd0);
    check("trap_valid", {31'd0, InstrValid}, 32'd0);
    check("trap_pc_kept", PC, 32'hF0);
    @(negedge clk);
    check("trap_req_stays", {31'd0, IMemReq}, 32'd0);
    check("trap_sticky", {31'd0, Trap}, 32'd1);
    reset_pulse();
    do_fetch(0, 32'h0000_0013, 1'b0);
`else
    do_commit(2'd2, 32'h0, 32'h203);
    check("jalr_addr", IMemAddr, 32'h200);
    do_fetch(0, 32'h0000_0013, 1'b0);
`endif

    do_commit(2'd1, 32'hFFFF_FFFC - exp_pc, 32'h0);
    check("top_addr", IMemAddr, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0000_0033, 1'b0);
    check("wrap_plus4", PCPlus4, 32'h0);
    do_commit(2'd1, 32'h8, 32'h0);
    check("wrap_addr", IMemAddr, 32'h4);
    do_fetch(0, 32'h0000_0093, 1'b0);
    do_commit(2'd3, 32'h40, 32'h80);
    check("reserved_src_addr", IMemAddr, 32'h8);
    do_fetch(2, 32'h0010_0113, 1'b0);

    do_commit(2'd0, 32'h0, 32'h0);
    check("wdog_c1", {31'd0, BusErr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wdog_pending", {31'd0, BusErr}, 32'd0);
      check("wdog_req", {31'd0, IMemReq}, 32'd1);
    end
    @(negedge clk);
    check("wdog_buserr", {31'd0, BusErr}, 32'd1);
    check("wdog_req_off", {31'd0, IMemReq}, 32'd0);
    check("wdog_valid_off", {31'd0, InstrValid}, 32'd0);
    IMemAck = 1'b1; IMemRdata = 32'hDEAD_BEEF; Commit = 1'b1;
    @(negedge clk);
    IMemAck = 1'b0; Commit = 1'b0;
    @(negedge clk);
    check("late_ack_buserr", {31'd0, BusErr}, 32'd1);
    check("late_ack_valid", {31'd0, InstrValid}, 32'd0);
    check("late_ack_instr", Instr, last_instr);
    check("late_ack_req", {31'd0, IMemReq}, 32'd0);
    reset_pulse();
    check("err_cleared", {31'd0, BusErr}, 32'd0);

    do_fetch(0, 32'h0050_0093, 1'b0);
    do_commit(2'd0, 32'h0, 32'h0);
    IMemAck = 1'b1; IMemRdata = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, IMemReq}, 32'd0);
    check("midrst_valid", {31'd0, InstrValid}, 32'd0);
    check("midrst_instr", Instr, 32'h0);
    check("midrst_pc", PC, 32'h0);
    check("midrst_buserr", {31'd0, BusErr}, 32'd0);
    @(negedge clk);
    check("midrst_instr_held", Instr, 32'h0);
    IMemAck = 1'b0;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    do_fetch(2, 32'h0000_0013, 1'b0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
